// File: rtl/ldpc_pkg.sv
// Shared constants and types for the GF(257) 4x24 LDPC decoder front end.
package ldpc_pkg;

    localparam int N               = 24;
    localparam int M               = 4;
    localparam int GF_ORDER        = 257;
    localparam int SYM_WIDTH       = 72;
    localparam int BANK_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } rd_state_t;

    // One-hot mask selecting a bank inside the per-bank status vector.
    function automatic logic [1:0] bank_mask(input logic bank);
        logic [1:0] mask;
        if (bank) begin
            mask = 2'b10;
        end else begin
            mask = 2'b01;
        end
        return mask;
    endfunction

endpackage

// File: rtl/in_info_pp_ram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port,
// the bank bit acting as the address MSB.
module in_info_pp_ram #(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_bank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [0:1][0:DEPTH-1];

    // Write port; storage is not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Registered read port, cleared on reset so the consumer sees zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem[rd_bank][rd_addr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/in_info_loader.sv
// in_info_loader: ping-pong channel-information buffer for the LDPC decoder;
// accepts frames on a valid/ready stream and serves the controller's read strobes.
module in_info_loader
    import ldpc_pkg::*;
#(
    parameter int FRAME_LEN  = N,
    parameter int DATA_WIDTH = SYM_WIDTH,
    parameter int ADDR_WIDTH = BANK_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  ini_st,
    input  logic                  in_info_rden,
    output logic [DATA_WIDTH-1:0] in_info_data,
    output logic                  in_info_vld,
    output logic                  frame_err,
    output logic [1:0]            bank_full
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

    rd_state_t             state_r;
    rd_state_t             state_nxt_s;
    logic                  st_cnt_r;
    logic                  wr_bank_r;
    logic                  rd_bank_r;
    logic [ADDR_WIDTH-1:0] wr_cnt_r;
    logic [ADDR_WIDTH-1:0] rd_cnt_r;

    logic                  accept_s;
    logic                  wr_last_s;
    logic                  commit_s;
    logic                  early_last_s;
    logic                  missing_last_s;
    logic                  rd_fire_s;
    logic                  release_s;
    logic                  stray_rd_s;
    logic                  ini_nxt_s;
    logic                  wr_bank_nxt_s;
    logic [1:0]            bank_full_nxt_s;

    // Write-side frame bookkeeping and the next bank-status vector.
    always_comb begin
        accept_s        = s_valid && s_ready;
        wr_last_s       = (wr_cnt_r == LAST_IDX);
        commit_s        = accept_s && wr_last_s;
        early_last_s    = accept_s && s_last && !wr_last_s;
        missing_last_s  = commit_s && !s_last;
        bank_full_nxt_s = bank_full;
        if (commit_s) begin
            bank_full_nxt_s = bank_full_nxt_s | bank_mask(wr_bank_r);
            wr_bank_nxt_s   = ~wr_bank_r;
        end else begin
            wr_bank_nxt_s   = wr_bank_r;
        end
        // Release always targets the other bank from any same-cycle commit.
        if (release_s) begin
            bank_full_nxt_s = bank_full_nxt_s & ~bank_mask(rd_bank_r);
        end else begin
            bank_full_nxt_s = bank_full_nxt_s;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bank_full[rd_bank_r]) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (st_cnt_r) begin
                    state_nxt_s = SERVE;
                end else begin
                    state_nxt_s = START;
                end
            end
            SERVE: begin
                if (in_info_rden && (rd_cnt_r == LAST_IDX)) begin
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            RELEASE: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read FSM output decode.
    always_comb begin
        rd_fire_s  = 1'b0;
        release_s  = 1'b0;
        stray_rd_s = 1'b0;
        case (state_r)
            SERVE:   rd_fire_s  = in_info_rden;
            RELEASE: begin
                release_s  = 1'b1;
                stray_rd_s = in_info_rden;
            end
            default: stray_rd_s = in_info_rden;
        endcase
        ini_nxt_s = (state_nxt_s == START);
    end

    // Counters, bank pointers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready     <= 1'b0;
            ini_st      <= 1'b0;
            in_info_vld <= 1'b0;
            frame_err   <= 1'b0;
            bank_full   <= 2'b00;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_cnt_r    <= {ADDR_WIDTH{1'b0}};
            rd_cnt_r    <= {ADDR_WIDTH{1'b0}};
            st_cnt_r    <= 1'b0;
        end else begin
            bank_full   <= bank_full_nxt_s;
            wr_bank_r   <= wr_bank_nxt_s;
            s_ready     <= ~bank_full_nxt_s[wr_bank_nxt_s];
            ini_st      <= ini_nxt_s;
            in_info_vld <= rd_fire_s;
            frame_err   <= early_last_s || missing_last_s || stray_rd_s;
            st_cnt_r    <= (state_r == START) ? ~st_cnt_r : 1'b0;
            if (commit_s || early_last_s) begin
                wr_cnt_r <= {ADDR_WIDTH{1'b0}};
            end else if (accept_s) begin
                wr_cnt_r <= wr_cnt_r + CNT_ONE;
            end
            if (release_s) begin
                rd_cnt_r  <= {ADDR_WIDTH{1'b0}};
                rd_bank_r <= ~rd_bank_r;
            end else if (rd_fire_s) begin
                rd_cnt_r  <= rd_cnt_r + CNT_ONE;
            end
        end
    end

    in_info_pp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FRAME_LEN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept_s),
        .wr_bank (wr_bank_r),
        .wr_addr (wr_cnt_r),
        .wr_data (s_data),
        .rd_en   (rd_fire_s),
        .rd_bank (rd_bank_r),
        .rd_addr (rd_cnt_r),
        .rd_data (in_info_data)
    );

endmodule

// File: doc/in_info_loader.md
Name: in_info_loader

Overview:
- Producer-side front end for the GF(257) 4x24 LDPC decoder: accepts one codeword's channel information, symbol by symbol, over a valid/ready stream.
- Stores each frame into a ping-pong (two-bank) buffer and kicks the decoder controller with a 2-cycle ini_st pulse once a full frame is present.
- Serves the controller's in_info_rden read strobes in order, then releases the bank. This is the writing/supplying end of the in_info interface that the controller reads.

Parameters:
- FRAME_LEN, 24, symbols per frame (code length N).
- DATA_WIDTH, 72, bits per symbol word (packed channel information).
- ADDR_WIDTH, 8, internal address width per bank; FRAME_LEN <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  input symbol valid
- s_ready  out  1  loader can accept a symbol this cycle
- s_data  in  DATA_WIDTH  input symbol
- s_last  in  1  marks the final symbol of a frame
- ini_st  out  1  decode start pulse to the controller, 2 cycles wide
- in_info_rden  in  1  controller read strobe, one symbol per strobe
- in_info_data  out  DATA_WIDTH  read data
- in_info_vld  out  1  in_info_data valid
- frame_err  out  1  1-cycle pulse on a framing or protocol error
- bank_full  out  2  per-bank full flags (status)

Behaviour:
- Reset (rst=1 at posedge) values: s_ready=0, ini_st=0, in_info_data=0, in_info_vld=0, frame_err=0, bank_full=2'b00, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, read FSM in IDLE.
- s_ready is 0 during the reset cycle and 1 from the first cycle after reset.
- Reset mid-frame or mid-read discards all buffered data and any ini_st in progress.
- Write side:
  - s_ready = !bank_full[wr_bank].
  - A symbol is accepted when s_valid && s_ready. It is written to mem[wr_bank][wr_cnt] and wr_cnt increments.
  - Accept with wr_cnt==FRAME_LEN-1 commits the frame: bank_full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
  - s_last on the final symbol: normal commit, no error.
  - s_last missing on the final symbol: frame still commits; frame_err pulses.
  - s_last on an earlier symbol (wr_cnt<FRAME_LEN-1): the partial frame is dropped, wr_cnt<=0, wr_bank is unchanged, frame_err pulses.
- Read FSM (IDLE -> START -> SERVE -> RELEASE -> IDLE):
  - IDLE: if bank_full[rd_bank], go to START.
  - START: ini_st=1 for exactly 2 cycles, then go to SERVE.
  - SERVE: each in_info_rden reads mem[rd_bank][rd_cnt]. in_info_data and in_info_vld are registered one cycle later (latency 1). rd_cnt increments; the read with rd_cnt==FRAME_LEN-1 moves to RELEASE.
  - RELEASE (1 cycle): bank_full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0, go to IDLE.
  - Minimum gap between back-to-back ini_st pulses is FRAME_LEN+4 cycles.
- in_info_rden outside SERVE is ignored: no data, in_info_vld stays 0, frame_err pulses.
- in_info_rden may be asserted every cycle in SERVE. Gaps between strobes are allowed.
- Simultaneous events:
  - A commit on one bank and a RELEASE on the other bank in the same cycle both take effect.
  - A RELEASE clearing the bank that wr_bank points to raises s_ready the next cycle.
- Both banks full: s_ready=0 until RELEASE. No data is ever overwritten.
- The memory is a plain register array or inferred RAM, 2*FRAME_LEN words, with a 1-cycle registered read.

Decomposition:
- Shared package ldpc_pkg holds:
  - FRAME_LEN/N=24, M=4, GF order 257
  - symbol DATA_WIDTH
  - read-FSM state encoding constants IDLE/START/SERVE/RELEASE
- One sub-module: in_info_pp_ram, a dual-bank simple dual-port RAM (1 write port, 1 registered read port, bank bit as address MSB).
- Counters and both FSMs stay in the top.

Test Plan:
- Single frame: 24 symbols with data=i and s_last on i=23 -> bank_full=01 one cycle after the last accept; ini_st high 2 cycles. 24 rden strobes -> in_info_data=0..23, each valid 1 cycle after its strobe; afterwards bank_full=00.
- Back-pressure: stream 72 symbols with no reads -> banks 0 and 1 fill, s_ready=0 after the 48th accept. Symbols 49+ are held; after the first 24 reads, RELEASE occurs and s_ready=1 the next cycle; the third frame lands in bank 0 with no data loss.
- Early s_last on symbol 10 -> frame_err pulse, no ini_st. The following clean 24-symbol frame reads back intact in bank 0.
- Missing s_last on symbol 23 -> frame_err pulse, frame still commits, ini_st fires.
- Stray rden in IDLE -> in_info_vld stays 0, frame_err pulse, rd_cnt remains 0.
- Reset asserted at symbol 12 of a frame and during SERVE read 5 -> all outputs at reset values, bank_full=00. A fresh frame afterwards decodes normally starting at bank 0.
